inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction-word builder; the encode-side counterpart of the instruction classifier. Accepts a decoded instruction description (class, subtype, condition and fields) through a valid/ready handshake. Packs it into a 32-bit ARM-format word, tags it with a running word address, and buffers it in a small FIFO for the instruction-memory loader. Illegal class/subtype combinations are dropped and flagged.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, address given to the first word after reset.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; equals (level < DEPTH).
- in_instype  in  2  1 = data, 2 = memory, 3 = branch, 0 = none (illegal).
- in_subtype  in  3  subtype within the class; legal values are listed under Operation.
- in_cond  in  4  condition field, goes to word[31:28].
- in_op  in  4  data: opcode; memory: {P,U,B,W}; multiply: op[0] = accumulate.
- in_s  in  1  data: S bit; memory: L bit.
- in_rn, in_rd, in_rs, in_rm  in  4 each  register fields.
- in_imm  in  24  immediate, shift, rotate or offset payload.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_word  out  32  encoded head word.
- out_addr  out  32  address tag of the head word.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- err  out  1  sticky illegal-request flag.
- err_clr  in  1  synchronous clear of err.

## Operation
- Accept: in_valid && in_ready at a rising edge.
- An accepted legal request writes one word and the current pc into the FIFO tail. pc then increments by 4, with 32-bit wrap.
- An accepted illegal request writes nothing, leaves pc unchanged and sets err.
- Data class, subtype 1 (immediate operand): {cond,2'b00,1,op,s,rn,rd,imm[11:0]}.
- Data class, subtype 2 (register, immediate shift): {cond,2'b00,0,op,s,rn,rd,imm[4:0],imm[6:5],0,rm}.
- Data class, subtype 3 (register, register shift): {cond,2'b00,0,op,s,rn,rd,rs,0,imm[6:5],1,rm}.
- Data class, subtype 4 (multiply): {cond,6'b000000,op[0],s,rd,rn,rs,4'b1001,rm}.
- Memory class, subtype 1 (register offset): {cond,2'b01,1,op,s,rn,rd,imm[4:0],imm[6:5],0,rm}.
- Memory class, subtype 2 (immediate offset): {cond,2'b01,0,op,s,rn,rd,imm[11:0]}.
- Branch class: {cond,3'b101,L,imm[23:0]}, with L = 0 for subtype 1 and L = 1 for subtype 2.
- Illegal: instype 0, and any subtype not listed above for its class.
- FIFO: circular read and write pointers of log2(DEPTH) bits that wrap naturally; level register.
- Simultaneous accept and pop: level unchanged; the pop reads the old head.
- Pop while empty: no effect. Push while full: impossible, because in_ready is 0.
- err: set on an illegal accept. err_clr clears it. If both happen in the same cycle, set wins.

## Timing
- Reset values: level 0, in_ready 1, out_valid 0, out_word 0, out_addr 0, err 0, pc = BASE_ADDR, pointers 0, FIFO storage 0.
- Reset takes effect immediately and asynchronously, mid-stream included; all buffered words are discarded.
- Latency: a word accepted at edge N drives out_word/out_valid from edge N onward if the FIFO was empty (one-cycle accept-to-visible). No combinational path from in_* to out_*.
- out_word and out_addr hold stable while out_valid && !out_ready.
- in_ready is a registered function of level; a pop in cycle N does not raise in_ready until after edge N (no full-bypass).
- Throughput: one word per cycle when out_ready is held at 1.

## Test plan
- Reset, then data subtype 1 with cond=E, op=4, s=1, rn=1, rd=2, imm=0x0FF -> word 0xE29120FF, out_addr 0x0, next edge level 1.
- Multiply with cond=E, op=1, s=0, rd=3, rn=4, rs=5, rm=6 -> word 0xE0234596; branch subtype 2 with cond=E, imm=0x000010 -> word 0xEB000010, out_addr 0x4.
- out_ready held 0, 5 legal pushes with DEPTH=4 -> in_ready drops after the 4th accept, level=4; one pop -> in_ready returns to 1 one cycle later, and addresses 0x0, 0x4, 0x8, 0xC come out in order.
- Illegal request (instype 0, then data subtype 5) between legal ones -> err=1, no word written, the next legal word gets the next consecutive address; err_clr -> err=0; err_clr together with an illegal accept -> err stays 1.
- Continuous push and pop at level 2 for 20 cycles -> level stays 2, words in order, pointers wrap cleanly.
- Assert rst with 3 words buffered, mid-cycle -> out_valid=0 and level=0 immediately; first word after release tagged BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder
//   Packs a decoded instruction description into a 32-bit ARM-format word,
//   tags it with a running word address and queues it for the
//   instruction-memory loader. Illegal class/subtype combinations are
//   dropped (no word, no address step) and raise a sticky error flag.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready request handshake (in_ready is registered)
//   in_instype        1 data, 2 memory, 3 branch, 0 illegal
//   in_subtype        subtype within the class
//   in_cond           condition field, word[31:28]
//   in_op, in_s       opcode / {P,U,B,W}; S / L bit
//   in_rn..in_rm      register fields
//   in_imm            immediate / shift / offset payload
//   out_valid/ready   FIFO head handshake
//   out_word/out_addr encoded head word and its address tag
//   level             FIFO occupancy
//   err, err_clr      sticky illegal-request flag and its clear
module inst_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_instype,
  input  logic [2:0]               in_subtype,
  input  logic [3:0]               in_cond,
  input  logic [3:0]               in_op,
  input  logic                     in_s,
  input  logic [3:0]               in_rn,
  input  logic [3:0]               in_rd,
  input  logic [3:0]               in_rs,
  input  logic [3:0]               in_rm,
  input  logic [23:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_word,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] CLS_DATA   = 2'd1;
  localparam logic [1:0] CLS_MEM    = 2'd2;
  localparam logic [1:0] CLS_BRANCH = 2'd3;

  logic [31:0]   r_word_mem [DEPTH];
  logic [31:0]   r_addr_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [31:0]   r_pc;
  logic          r_err;
  logic          r_in_ready;

  logic          w_legal;
  logic [31:0]   w_word;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_level_nxt;

  // Word packing; w_legal marks the class/subtype pairs that have an encoding.
  always_comb begin
    w_legal = 1'b0;
    w_word  = '0;
    case (in_instype)
      CLS_DATA: begin
        case (in_subtype)
          3'd1: begin
            w_legal = 1'b1;
            w_word  = {in_cond, 2'b00, 1'b1, in_op, in_s, in_rn, in_rd, in_imm[11:0]};
          end
          3'd2: begin
            w_legal = 1'b1;
            w_word  = {in_cond, 2'b00, 1'b0, in_op, in_s, in_rn, in_rd,
                       in_imm[4:0], in_imm[6:5], 1'b0, in_rm};
          end
          3'd3: begin
            w_legal = 1'b1;
            w_word  = {in_cond, 2'b00, 1'b0, in_op, in_s, in_rn, in_rd,
                       in_rs, 1'b0, in_imm[6:5], 1'b1, in_rm};
          end
          3'd4: begin
            // Multiply swaps the rd/rn nibble positions relative to data ops.
            w_legal = 1'b1;
            w_word  = {in_cond, 6'b000000, in_op[0], in_s, in_rd, in_rn, in_rs,
                       4'b1001, in_rm};
          end
          default: begin
            w_legal = 1'b0;
            w_word  = '0;
          end
        endcase
      end
      CLS_MEM: begin
        case (in_subtype)
          3'd1: begin
            w_legal = 1'b1;
            w_word  = {in_cond, 2'b01, 1'b1, in_op, in_s, in_rn, in_rd,
                       in_imm[4:0], in_imm[6:5], 1'b0, in_rm};
          end
          3'd2: begin
            w_legal = 1'b1;
            w_word  = {in_cond, 2'b01, 1'b0, in_op, in_s, in_rn, in_rd, in_imm[11:0]};
          end
          default: begin
            w_legal = 1'b0;
            w_word  = '0;
          end
        endcase
      end
      CLS_BRANCH: begin
        case (in_subtype)
          3'd1: begin
            w_legal = 1'b1;
            w_word  = {in_cond, 3'b101, 1'b0, in_imm};
          end
          3'd2: begin
            w_legal = 1'b1;
            w_word  = {in_cond, 3'b101, 1'b1, in_imm};
          end
          default: begin
            w_legal = 1'b0;
            w_word  = '0;
          end
        endcase
      end
      default: begin
        w_legal = 1'b0;
        w_word  = '0;
      end
    endcase
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = out_valid && out_ready;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_word_mem[i] <= '0;
        r_addr_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_pc       <= BASE_ADDR;
      r_err      <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_word_mem[r_wr_ptr] <= w_word;
        r_addr_mem[r_wr_ptr] <= r_pc;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
        r_pc                 <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level    <= w_level_nxt;
      // Registered from the next level so a pop never bypasses into in_ready.
      r_in_ready <= (w_level_nxt < LVL_FULL);
      // Set has priority over clear.
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_level != '0);
  assign out_word  = r_word_mem[r_rd_ptr];
  assign out_addr  = r_addr_mem[r_rd_ptr];
  assign level     = r_level;
  assign err       = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_instype = '0;
  logic [2:0]  in_subtype = '0;
  logic [3:0]  in_cond = '0;
  logic [3:0]  in_op = '0;
  logic        in_s = 1'b0;
  logic [3:0]  in_rn = '0;
  logic [3:0]  in_rd = '0;
  logic [3:0]  in_rs = '0;
  logic [3:0]  in_rm = '0;
  logic [23:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [2:0]  level;
  logic        err;
  logic        err_clr = 1'b0;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instype(in_instype), .in_subtype(in_subtype), .in_cond(in_cond),
    .in_op(in_op), .in_s(in_s), .in_rn(in_rn), .in_rd(in_rd), .in_rs(in_rs),
    .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .level(level), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] sb[$];
  int          m_level = 0;
  logic [31:0] m_pc = BASE_ADDR;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference packing, built bit-field by bit-field; bit 32 = legal.
  function automatic logic [32:0] model_enc();
    logic [31:0] w;
    logic        ok;
    w  = '0;
    ok = 1'b1;
    w[31:28] = in_cond;
    if (in_instype == 2'd1 && in_subtype >= 3'd1 && in_subtype <= 3'd3) begin
      w[25] = (in_subtype == 3'd1);
      w[24:21] = in_op; w[20] = in_s; w[19:16] = in_rn; w[15:12] = in_rd;
      if (in_subtype == 3'd1) w[11:0] = in_imm[11:0];
      else begin
        w[6:5] = in_imm[6:5]; w[3:0] = in_rm;
        if (in_subtype == 3'd2) w[11:7] = in_imm[4:0];
        else begin w[11:8] = in_rs; w[4] = 1'b1; end
      end
    end else if (in_instype == 2'd1 && in_subtype == 3'd4) begin
      w[21] = in_op[0]; w[20] = in_s; w[19:16] = in_rd; w[15:12] = in_rn;
      w[11:8] = in_rs; w[7:4] = 4'b1001; w[3:0] = in_rm;
    end else if (in_instype == 2'd2 && (in_subtype == 3'd1 || in_subtype == 3'd2)) begin
      w[26] = 1'b1; w[25] = (in_subtype == 3'd1);
      w[24:21] = in_op; w[20] = in_s; w[19:16] = in_rn; w[15:12] = in_rd;
      if (in_subtype == 3'd2) w[11:0] = in_imm[11:0];
      else begin w[11:7] = in_imm[4:0]; w[6:5] = in_imm[6:5]; w[3:0] = in_rm; end
    end else if (in_instype == 2'd3 && (in_subtype == 3'd1 || in_subtype == 3'd2)) begin
      w[27:25] = 3'b101; w[24] = (in_subtype == 3'd2); w[23:0] = in_imm;
    end else begin
      ok = 1'b0;
      w  = '0;
    end
    return {ok, w};
  endfunction

  // One clock: score the handshakes at the current (negedge) sample point,
  // advance to the next negedge and check the state outputs against the model.
  task automatic cycle();
    logic        acc, pop;
    logic [32:0] m;
    logic [63:0] e;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    m   = model_enc();
    if (pop) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_word", out_word, e[31:0]);
        chk("sb_addr", out_addr, e[63:32]);
      end
      m_level--;
    end
    if (acc && m[32]) begin
      sb.push_back({m_pc, m[31:0]});
      m_pc = m_pc + 32'd4;
      m_level++;
    end
    if (acc && !m[32]) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("level", 32'(level), 32'(m_level));
    chk("in_ready", 32'(in_ready), 32'(m_level < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(m_level != 0));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic set_req(input logic [1:0] t, input logic [2:0] st, input logic [3:0] c,
                         input logic [3:0] op, input logic s, input logic [3:0] rn,
                         input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rm,
                         input logic [23:0] imm);
    in_valid = 1'b1; in_instype = t; in_subtype = st; in_cond = c; in_op = op;
    in_s = s; in_rn = rn; in_rd = rd; in_rs = rs; in_rm = rm; in_imm = imm;
  endtask

  task automatic rand_legal();
    int k;
    k = int'($urandom_range(0, 7));
    if (k < 4)      begin in_instype = 2'd1; in_subtype = 3'(k + 1); end
    else if (k < 6) begin in_instype = 2'd2; in_subtype = 3'(k - 3); end
    else            begin in_instype = 2'd3; in_subtype = 3'(k - 5); end
    in_valid = 1'b1;
    in_cond = 4'($urandom); in_op = 4'($urandom); in_s = 1'($urandom);
    in_rn = 4'($urandom); in_rd = 4'($urandom); in_rs = 4'($urandom);
    in_rm = 4'($urandom); in_imm = 24'($urandom);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Directed encodings.
    out_ready = 1'b0;
    set_req(2'd1, 3'd1, 4'hE, 4'd4, 1'b1, 4'd1, 4'd2, 4'd0, 4'd0, 24'h0000FF);
    cycle();
    chk("dp_imm_word", out_word, 32'hE29120FF);
    chk("dp_imm_addr", out_addr, 32'h0);
    set_req(2'd3, 3'd2, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000010);
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bl_word", out_word, 32'hEB000010);
    chk("bl_addr", out_addr, 32'h4);
    set_req(2'd1, 3'd4, 4'hE, 4'd1, 1'b0, 4'd4, 4'd3, 4'd5, 4'd6, 24'h0);
    cycle();
    chk("mul_word", out_word, 32'hE0234596);
    chk("mul_addr", out_addr, 32'h8);
    in_valid = 1'b0;
    cycle();

    // Fill to full, one pop, then the held fifth request goes in.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_legal(); cycle(); end
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Illegal requests and the sticky flag.
    rand_legal(); cycle();
    set_req(2'd0, 3'd1, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0); cycle();
    chk("illegal0_err", 32'(err), 32'd1);
    set_req(2'd1, 3'd5, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0); cycle();
    set_req(2'd2, 3'd3, 4'h1, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0); cycle();
    set_req(2'd3, 3'd0, 4'h2, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0); cycle();
    rand_legal(); cycle();
    in_valid = 1'b0; err_clr = 1'b1; cycle();
    chk("err_cleared", 32'(err), 32'd0);
    err_clr = 1'b0;
    set_req(2'd1, 3'd7, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0); cycle();
    err_clr = 1'b1;
    set_req(2'd0, 3'd2, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0); cycle();
    chk("set_wins", 32'(err), 32'd1);
    in_valid = 1'b0; cycle();
    err_clr = 1'b0;
    cycle(); cycle();

    // Steady push/pop at level 2 across several pointer wraps.
    out_ready = 1'b0;
    rand_legal(); cycle();
    rand_legal(); cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin rand_legal(); cycle(); end
    chk("stream_level", 32'(level), 32'd2);
    in_valid = 1'b0;
    cycle(); cycle(); cycle();

    // Asynchronous reset with three words buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_legal(); cycle(); end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_word", out_word, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); m_level = 0; m_pc = BASE_ADDR; m_err = 1'b0;
    rand_legal(); cycle();
    chk("post_rst_addr", out_addr, BASE_ADDR);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
